iter_div_axis: RTL and testbench
================================

// Module: iter_div_axis
// PURPOSE
//  Iterative radix-2 restoring divider: AXI-stream responder for the EX-stage divide handshake.
//  Accepts dividend/divisor on two slave channels; returns {quotient, remainder} on one master channel.
//  Drop-in replacement for the vendor divider IP behind div/mod/divu/modu (one instance per signedness).
// PARAMETERS
//  WIDTH   32  operand width; dout is 2*WIDTH
//  SIGNED  1   1: two's-complement div/mod; 0: unsigned divu/modu
// PORTS
//  clk                     in   1        single clock, rising edge
//  rst                     in   1        asynchronous, active-high reset
//  s_axis_dividend_tdata   in   WIDTH    dividend (rj)
//  s_axis_dividend_tvalid  in   1        dividend valid
//  s_axis_dividend_tready  out  1        dividend ready
//  s_axis_divisor_tdata    in   WIDTH    divisor (rk)
//  s_axis_divisor_tvalid   in   1        divisor valid
//  s_axis_divisor_tready   out  1        divisor ready
//  cancel                  in   1        abort in-flight op (EX flush/exception)
//  m_axis_dout_tdata       out  2*WIDTH  {quotient[2W-1:W], remainder[W-1:0]}
//  m_axis_dout_tvalid      out  1        result valid, 1-cycle pulse, no tready
// BEHAVIOUR
//  - States: IDLE, CALC, DONE. Reset: state=IDLE, cnt=0, dout_tvalid=0, dout_tdata=0.
//  - Both tready = (state==IDLE) & ~rst; identical on both channels.
//  - Accept = IDLE & both tvalid & ~cancel. A lone tvalid is NOT consumed; master drives both together.
//  - At accept edge: latch |dividend|, |divisor| (abs only if SIGNED), latch signs; rem_acc=0; cnt=0; ->CALC.
//  - CALC: one quotient bit per cycle, MSB first: trial = {rem_acc,next dividend bit} - divisor;
//    bit=~borrow; restore on borrow. 32 edges (cnt 0..WIDTH-1); final edge applies sign fix-up,
//    registers dout_tdata, ->DONE.
//  - DONE: dout_tvalid=1 for exactly one cycle, then ->IDLE (tready high again next cycle).
//  - Latency: dout_tvalid high in cycle WIDTH after the accept edge (accept edge E0, tvalid after E32);
//    back-to-back issue period WIDTH+2 cycles.
//  - dout_tdata holds last result until the next completion; tvalid alone qualifies it.
//  - Signed fix-up: quotient negated if signs differ (truncate toward zero); remainder takes dividend sign.
//  - Divide by zero (either mode): quotient = all ones, remainder = original dividend. Bypasses fix-up.
//  - Signed overflow 0x8000_0000 / -1: quotient = 0x8000_0000, remainder = 0.
//  - Magnitudes held in WIDTH+1 bits internally so |0x8000_0000| is exact.
//  - cancel in CALC or DONE: ->IDLE next edge, dout_tvalid forced 0 (cancel beats completion same cycle).
//  - cancel in IDLE blocks accept that cycle. tvalid during CALC/DONE ignored (tready=0).
//  - rst mid-operation: immediate return to reset values; no stale tvalid after release.
// STRUCTURE
//  - Shared header div_defs.vh: state encodings (DIV_IDLE/DIV_CALC/DIV_DONE),
//    DIV_DOUT_W=2*WIDTH, div-by-zero quotient constant.
//  - Sub-module div_iter_step (combinational): {rem_in,bit_in,divisor} -> {rem_out,q_bit}.
//  - Top holds FSM, cnt ($clog2(WIDTH) bits), shift registers, sign fix-up, output register.
// TESTING
//  - SIGNED=1, 100/7 -> dout_tvalid 32 cycles after accept, tdata={0x0000000E,0x00000002}, 1-cycle pulse.
//  - SIGNED=1, -7/2 -> {0xFFFFFFFD,0xFFFFFFFF}; 7/-2 -> {0xFFFFFFFD,0x00000001}.
//  - SIGNED=1, 0x80000000/0xFFFFFFFF -> {0x80000000,0}. SIGNED=0, 0xFFFFFFFF/2 -> {0x7FFFFFFF,1}.
//  - Divisor 0, dividend 5 (both modes) -> {0xFFFFFFFF,0x00000005}.
//  - Only dividend_tvalid high 5 cycles -> no accept, tready stays 1; tvalid pulsed mid-CALC -> ignored.
//  - cancel at cycle 10 of CALC -> no tvalid ever, tready=1 next cycle; following 9/3 -> {3,0}.
//    Async rst mid-CALC -> tvalid=0 immediately, tready=1 after release.

Source files
------------

// File: rtl/iter_div_axis_pkg.sv
// Shared definitions for the iterative restoring divider: FSM encodings,
// output width helper and the divide-by-zero quotient fill bit.
package iter_div_axis_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Quotient returned on divide-by-zero is this bit replicated across the word.
  localparam logic DIV_DZ_Q_BIT = 1'b1;

  function automatic int div_dout_w(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/iter_div_axis_div_iter_step.sv
// One radix-2 restoring step: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and report the quotient bit.
module div_iter_step
  import iter_div_axis_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH:0]   divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] trial_in;
  logic           borrow;

  // The remainder is always below the divisor, so after a successful
  // subtraction the result fits back into WIDTH bits.
  always_comb begin
    trial_in = {rem_in, bit_in};
    borrow   = (trial_in < divisor);
    q_bit    = ~borrow;
    rem_out  = trial_in[WIDTH-1:0] - (q_bit ? divisor[WIDTH-1:0] : '0);
  end

endmodule

// File: rtl/iter_div_axis.sv
// Iterative radix-2 restoring divider with AXI-stream style handshake:
// one quotient bit per cycle, signed or unsigned, with cancel support.
module iter_div_axis
  import iter_div_axis_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
  input  logic               s_axis_dividend_tvalid,
  output logic               s_axis_dividend_tready,
  input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
  input  logic               s_axis_divisor_tvalid,
  output logic               s_axis_divisor_tready,
  input  logic               cancel,
  output logic [2*WIDTH-1:0] m_axis_dout_tdata,
  output logic               m_axis_dout_tvalid
);

  localparam int DOUT_W = div_dout_w(WIDTH);
  localparam int CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  div_state_e state_q, state_d;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  dvd_q, dvd_d;
  logic [WIDTH-1:0]  quo_q, quo_d;
  logic [WIDTH-1:0]  rem_q, rem_d;
  logic [WIDTH:0]    dsr_q, dsr_d;
  logic [WIDTH-1:0]  orig_q, orig_d;
  logic              q_neg_q, q_neg_d;
  logic              r_neg_q, r_neg_d;
  logic [DOUT_W-1:0] dout_q, dout_d;
  logic              tvalid_q, tvalid_d;

  logic              accept;
  logic              last_step;
  logic              dvd_neg;
  logic              dsr_neg;
  logic [WIDTH-1:0]  dvd_mag;
  logic [WIDTH-1:0]  dsr_abs;
  logic [WIDTH-1:0]  step_rem;
  logic              step_q;
  logic [WIDTH-1:0]  quo_raw;
  logic [WIDTH-1:0]  quo_fix;
  logic [WIDTH-1:0]  rem_fix;
  logic [DOUT_W-1:0] result;

  div_iter_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in  (rem_q),
    .bit_in  (dvd_q[WIDTH-1]),
    .divisor (dsr_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_comb begin
    accept    = (state_q == DIV_IDLE) && s_axis_dividend_tvalid &&
                s_axis_divisor_tvalid && !cancel;
    last_step = (state_q == DIV_CALC) && (cnt_q == CNT_LAST);
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DIV_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_IDLE: if (accept) state_d = DIV_CALC;
      DIV_CALC: begin
        if (cancel) begin
          state_d = DIV_IDLE;
        end else if (last_step) begin
          state_d = DIV_DONE;
        end
      end
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    s_axis_dividend_tready = (state_q == DIV_IDLE) && !rst;
    s_axis_divisor_tready  = (state_q == DIV_IDLE) && !rst;
    m_axis_dout_tvalid     = tvalid_q;
    m_axis_dout_tdata      = dout_q;
  end

  // Operand magnitudes; the two's-complement negate of the most negative
  // value yields the correct unsigned magnitude.
  always_comb begin
    dvd_neg = SIGNED && s_axis_dividend_tdata[WIDTH-1];
    dsr_neg = SIGNED && s_axis_divisor_tdata[WIDTH-1];
    dvd_mag = dvd_neg ? -s_axis_dividend_tdata : s_axis_dividend_tdata;
    dsr_abs = dsr_neg ? -s_axis_divisor_tdata : s_axis_divisor_tdata;
  end

  // Final result; a zero divisor bypasses the sign fix-up entirely.
  always_comb begin
    quo_raw = {quo_q[WIDTH-2:0], step_q};
    quo_fix = q_neg_q ? -quo_raw : quo_raw;
    rem_fix = r_neg_q ? -step_rem : step_rem;
    if (dsr_q == '0) begin
      result = {{WIDTH{DIV_DZ_Q_BIT}}, orig_q};
    end else begin
      result = {quo_fix, rem_fix};
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dsr_d    = dsr_q;
    orig_d   = orig_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    dout_d   = dout_q;
    tvalid_d = 1'b0;
    if (accept) begin
      cnt_d   = '0;
      dvd_d   = dvd_mag;
      quo_d   = '0;
      rem_d   = '0;
      dsr_d   = {1'b0, dsr_abs};
      orig_d  = s_axis_dividend_tdata;
      q_neg_d = dvd_neg ^ dsr_neg;
      r_neg_d = dvd_neg;
    end else if (state_q == DIV_CALC) begin
      cnt_d = cnt_q + 1'b1;
      dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
      quo_d = quo_raw;
      rem_d = step_rem;
      // A cancel on the final step wins over completion.
      if (last_step && !cancel) begin
        dout_d   = result;
        tvalid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      dvd_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dsr_q    <= '0;
      orig_q   <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      dout_q   <= '0;
      tvalid_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dsr_q    <= dsr_d;
      orig_q   <= orig_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      dout_q   <= dout_d;
      tvalid_q <= tvalid_d;
    end
  end

endmodule

// File: tb/tb_iter_div_axis.sv
// Randomised bench for iter_div_axis: a signed and an unsigned instance share
// stimulus and are checked every cycle against an arithmetic reference model.
module tb_iter_div_axis;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] da = '0;
  logic [31:0] db = '0;
  logic        va = 1'b0;
  logic        vb = 1'b0;
  logic        cancel = 1'b0;

  logic        rdy_a_s, rdy_b_s, val_s;
  logic        rdy_a_u, rdy_b_u, val_u;
  logic [63:0] dout_s, dout_u;

  always #5 clk = ~clk;

  iter_div_axis #(.WIDTH(32), .SIGNED(1'b1)) u_dut_s (
    .clk                    (clk),
    .rst                    (rst),
    .s_axis_dividend_tdata  (da),
    .s_axis_dividend_tvalid (va),
    .s_axis_dividend_tready (rdy_a_s),
    .s_axis_divisor_tdata   (db),
    .s_axis_divisor_tvalid  (vb),
    .s_axis_divisor_tready  (rdy_b_s),
    .cancel                 (cancel),
    .m_axis_dout_tdata      (dout_s),
    .m_axis_dout_tvalid     (val_s)
  );

  iter_div_axis #(.WIDTH(32), .SIGNED(1'b0)) u_dut_u (
    .clk                    (clk),
    .rst                    (rst),
    .s_axis_dividend_tdata  (da),
    .s_axis_dividend_tvalid (va),
    .s_axis_dividend_tready (rdy_a_u),
    .s_axis_divisor_tdata   (db),
    .s_axis_divisor_tvalid  (vb),
    .s_axis_divisor_tready  (rdy_b_u),
    .cancel                 (cancel),
    .m_axis_dout_tdata      (dout_u),
    .m_axis_dout_tvalid     (val_u)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state: cycle count, when the unit is free again, the
  // cycle the pending result must appear, and the value the output holds.
  int          cyc      = 0;
  int          free_cyc = 0;
  int          done_cyc = -10;
  int          acc_cyc  = -10;
  bit          pend     = 1'b0;
  bit          tb_done  = 1'b0;
  logic [63:0] exp_s    = '0;
  logic [63:0] exp_u    = '0;
  logic [63:0] last_s   = '0;
  logic [63:0] last_u   = '0;
  logic [31:0] txn_a    = '0;
  logic [31:0] txn_b    = '0;

  function automatic logic [63:0] model_div(input logic [31:0] a, input logic [31:0] b,
                                            input bit sgn);
    int sa;
    int sb;
    if (b == 32'h0) return {32'hFFFF_FFFF, a};
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
      sa = a;
      sb = b;
      return {32'(sa / sb), 32'(sa % sb)};
    end
    return {a / b, a % b};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic note_timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=timeout expected=event (cycle %0d)", name, cyc);
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      pend     <= 1'b0;
      free_cyc <= cyc + 1;
      last_s   <= '0;
      last_u   <= '0;
    end else begin
      if (cyc >= free_cyc) begin
        if (va && vb && !cancel) begin
          pend     <= 1'b1;
          acc_cyc  <= cyc + 1;
          done_cyc <= cyc + 33;
          free_cyc <= cyc + 34;
          exp_s    <= model_div(da, db, 1'b1);
          exp_u    <= model_div(da, db, 1'b0);
          txn_a    <= da;
          txn_b    <= db;
        end
      end else if (cancel) begin
        if (cyc < done_cyc) pend <= 1'b0;
        free_cyc <= cyc + 1;
      end
      if (pend && (cyc + 1 == done_cyc) && !cancel) begin
        last_s <= exp_s;
        last_u <= exp_u;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && !tb_done) begin
      chk("tready_dividend_s", 64'(rdy_a_s), 64'(cyc >= free_cyc));
      chk("tready_divisor_s",  64'(rdy_b_s), 64'(cyc >= free_cyc));
      chk("tready_dividend_u", 64'(rdy_a_u), 64'(cyc >= free_cyc));
      chk("tready_divisor_u",  64'(rdy_b_u), 64'(cyc >= free_cyc));
      chk("tvalid_s", 64'(val_s), 64'(pend && cyc == done_cyc));
      chk("tvalid_u", 64'(val_u), 64'(pend && cyc == done_cyc));
      chk("tdata_s", dout_s, last_s);
      chk("tdata_u", dout_u, last_u);
      if (pend && cyc == done_cyc)
        $display("txn a=%h b=%h signed=%h unsigned=%h", txn_a, txn_b, dout_s, dout_u);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input int blk);
    bit ok;
    da     = a;
    db     = b;
    va     = 1'b1;
    vb     = 1'b1;
    cancel = (blk > 0);
    for (int i = 0; i < blk; i++) step();
    cancel = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (acc_cyc == cyc) begin
        ok = 1'b1;
        break;
      end
    end
    va = 1'b0;
    vb = 1'b0;
    if (!ok) note_timeout("accept");
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (cyc >= free_cyc) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) note_timeout("return_to_idle");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    int          k;

    step();
    step();
    chk("reset_tready", 64'(rdy_a_s), 64'(0));
    chk("reset_tvalid", 64'(val_s), 64'(0));
    chk("reset_tdata_s", dout_s, 64'h0);
    chk("reset_tdata_u", dout_u, 64'h0);
    rst = 1'b0;
    #1;
    chk("release_tready", 64'(rdy_a_s), 64'(1));

    chk("model_100_7", model_div(32'd100, 32'd7, 1'b1), {32'h0000_000E, 32'h0000_0002});
    chk("model_m7_2", model_div(32'hFFFF_FFF9, 32'd2, 1'b1), {32'hFFFF_FFFD, 32'hFFFF_FFFF});
    chk("model_ovf", model_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1), {32'h8000_0000, 32'h0});
    chk("model_u_max_2", model_div(32'hFFFF_FFFF, 32'd2, 1'b0), {32'h7FFF_FFFF, 32'h1});
    step();

    issue(32'd100, 32'd7, 0);
    wait_idle();
    chk("lit_100_7_s", dout_s, {32'h0000_000E, 32'h0000_0002});
    issue(32'hFFFF_FFF9, 32'd2, 0);
    wait_idle();
    chk("lit_m7_2_s", dout_s, {32'hFFFF_FFFD, 32'hFFFF_FFFF});
    issue(32'd7, 32'hFFFF_FFFE, 0);
    wait_idle();
    chk("lit_7_m2_s", dout_s, {32'hFFFF_FFFD, 32'h0000_0001});
    issue(32'h8000_0000, 32'hFFFF_FFFF, 0);
    wait_idle();
    chk("lit_ovf_s", dout_s, {32'h8000_0000, 32'h0});
    issue(32'hFFFF_FFFF, 32'd2, 0);
    wait_idle();
    chk("lit_umax_2_u", dout_u, {32'h7FFF_FFFF, 32'h1});
    issue(32'd5, 32'd0, 1);
    wait_idle();
    chk("lit_div0_s", dout_s, {32'hFFFF_FFFF, 32'h5});
    chk("lit_div0_u", dout_u, {32'hFFFF_FFFF, 32'h5});

    // A lone valid on either channel must not be consumed.
    da = 32'd42;
    va = 1'b1;
    repeat (5) step();
    va = 1'b0;
    db = 32'd6;
    vb = 1'b1;
    repeat (3) step();
    vb = 1'b0;
    step();

    issue(32'd1000, 32'd10, 0);
    repeat (5) step();
    da = 32'd3;
    db = 32'd1;
    va = 1'b1;
    vb = 1'b1;
    step();
    va = 1'b0;
    vb = 1'b0;
    wait_idle();
    chk("lit_ignore_midcalc", dout_s, {32'd100, 32'd0});

    issue(32'd123456, 32'd7, 0);
    repeat (10) step();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    chk("cancel_tready", 64'(rdy_a_s), 64'(1));
    repeat (40) step();
    issue(32'd9, 32'd3, 0);
    wait_idle();
    chk("lit_after_cancel", dout_s, {32'd3, 32'd0});

    issue(32'd77, 32'd5, 0);
    repeat (5) step();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_calc_tvalid", 64'(val_s), 64'(0));
    chk("rst_calc_tready", 64'(rdy_a_s), 64'(0));
    chk("rst_calc_tdata", dout_s, 64'h0);
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_release_tready", 64'(rdy_a_s), 64'(1));
    step();

    issue(32'd50, 32'd5, 0);
    for (int i = 0; i < 100 && cyc != done_cyc; i++) step();
    chk("done_pulse", 64'(val_s), 64'(1));
    #1;
    rst = 1'b1;
    #1;
    chk("rst_done_tvalid", 64'(val_s), 64'(0));
    chk("rst_done_tdata", dout_u, 64'h0);
    step();
    step();
    rst = 1'b0;
    step();

    for (int n = 0; n < 80; n++) begin
      a = $urandom;
      if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
      case ($urandom_range(0, 9))
        0:       b = 32'h0;
        1:       b = 32'h1;
        2:       b = 32'hFFFF_FFFF;
        3:       b = 32'($urandom_range(1, 15));
        4:       b = -32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      issue(a, b, ($urandom_range(0, 7) == 0) ? 1 : 0);
      if ($urandom_range(0, 5) == 0) begin
        k = $urandom_range(0, 34);
        repeat (k) step();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
      end
      wait_idle();
      repeat ($urandom_range(0, 3)) step();
    end

    step();
    tb_done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
